// File: rtl/adder_pipe_carry_amisha.sv
// Pipelined N-bit adder/subtractor: carry ripples through STAGES registered W-bit chunks.
// Each stage rotates its operand register right by W, parking the new sum chunk on top.
module adder_pipe_carry_amisha #(
   parameter int unsigned N      = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic         clk_amisha,
   input  logic         rst_n_amisha,
   input  logic         in_valid_amisha,
   input  logic         sub_amisha,
   input  logic         flush_amisha,
   input  logic [N-1:0] a_amisha,
   input  logic [N-1:0] b_amisha,
   output logic         out_valid_amisha,
   output logic [N-1:0] sum_amisha,
   output logic         cout_amisha,
   output logic         ovf_amisha
);

   localparam int unsigned W = N / STAGES;

   logic [N-1:0] b_eff;

   // Per-stage combinational inputs and results
   logic         v_in   [STAGES];
   logic         c_in   [STAGES];
   logic [N-1:0] acc_in [STAGES];
   logic [N-1:0] bop_in [STAGES];
   logic         as_in  [STAGES];
   logic         bs_in  [STAGES];
   logic [W:0]   chunk  [STAGES];
   logic [N-1:0] acc_d  [STAGES];
   logic [N-1:0] bop_d  [STAGES];

   // Per-stage registers
   logic         valid_q [STAGES];
   logic         carry_q [STAGES];
   logic [N-1:0] acc_q   [STAGES];
   logic [N-1:0] bop_q   [STAGES];
   logic         as_q    [STAGES];
   logic         bs_q    [STAGES];

   assign b_eff = sub_amisha ? ~b_amisha : b_amisha;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign v_in[k]   = in_valid_amisha;
         assign c_in[k]   = sub_amisha;
         assign acc_in[k] = a_amisha;
         assign bop_in[k] = b_eff;
         assign as_in[k]  = a_amisha[N-1];
         assign bs_in[k]  = b_eff[N-1];
      end else begin : g_next
         assign v_in[k]   = valid_q[k-1];
         assign c_in[k]   = carry_q[k-1];
         assign acc_in[k] = acc_q[k-1];
         assign bop_in[k] = bop_q[k-1];
         assign as_in[k]  = as_q[k-1];
         assign bs_in[k]  = bs_q[k-1];
      end

      assign chunk[k] = {1'b0, acc_in[k][W-1:0]} + {1'b0, bop_in[k][W-1:0]}
                      + {{W{1'b0}}, c_in[k]};
      // Lowest unprocessed a chunk drops off the bottom, finished sum chunk enters at the top;
      // after STAGES rotations the register holds the sum in natural bit order.
      assign acc_d[k] = (acc_in[k] >> W) | (N'(chunk[k][W-1:0]) << (N - W));
      assign bop_d[k] = bop_in[k] >> W;
   end

   always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
      if (!rst_n_amisha) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            acc_q[k]   <= '0;
            bop_q[k]   <= '0;
            as_q[k]    <= 1'b0;
            bs_q[k]    <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= v_in[k] & ~flush_amisha;
            carry_q[k] <= chunk[k][W];
            acc_q[k]   <= acc_d[k];
            bop_q[k]   <= bop_d[k];
            as_q[k]    <= as_in[k];
            bs_q[k]    <= bs_in[k];
         end
      end
   end

   assign out_valid_amisha = valid_q[STAGES-1];
   assign sum_amisha       = acc_q[STAGES-1];
   assign cout_amisha      = carry_q[STAGES-1];
   assign ovf_amisha       = (as_q[STAGES-1] == bs_q[STAGES-1])
                          && (acc_q[STAGES-1][N-1] != as_q[STAGES-1]);

endmodule

// File: tb/tb_adder_pipe_carry_amisha.sv
// Bench for adder_pipe_carry_amisha: five configurations share one random stimulus stream and
// are scored every cycle against a plain-integer arithmetic model.
module tb_adder_pipe_carry_amisha;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        sub;
   logic        flush;
   logic [31:0] a_drv;
   logic [31:0] b_drv;
   longint      cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          acc_total = 0;
   int          out_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
   function automatic logic [33:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      longint md, half, ua, ub, sa, sb, ur, sr;
      logic   c, o;
      md   = longint'(1) << n;
      half = md / 2;
      ua   = longint'(a) % md;
      ub   = longint'(b) % md;
      sa   = (ua >= half) ? ua - md : ua;
      sb   = (ub >= half) ? ub - md : ub;
      if (s) begin
         ur = ua - ub;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub;
         c  = (ur >= md);
         sr = sa + sb;
      end
      o  = (sr >= half) || (sr < -half);
      ur = ((ur % md) + md) % md;
      return {o, c, 32'(ur)};
   endfunction

   for (genvar i = 0; i < 5; i++) begin : g_cfg
      localparam int unsigned NI = (i == 0) ? 16 : (i == 1) ? 8 : (i == 2) ? 16 : (i == 3) ? 32 : 12;
      localparam int unsigned SI = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 8 : 3;

      logic [NI-1:0] a_i, b_i, sum_o;
      logic          vo, co, ov;
      longint        due_q[$];
      logic [33:0]   exp_q[$];
      logic          exp_v;

      assign a_i = a_drv[NI-1:0];
      assign b_i = b_drv[NI-1:0];

      adder_pipe_carry_amisha #(
         .N      (NI),
         .STAGES (SI)
      ) u_dut (
         .clk_amisha       (clk),
         .rst_n_amisha     (rst_n),
         .in_valid_amisha  (in_valid),
         .sub_amisha       (sub),
         .flush_amisha     (flush),
         .a_amisha         (a_i),
         .b_amisha         (b_i),
         .out_valid_amisha (vo),
         .sum_amisha       (sum_o),
         .cout_amisha      (co),
         .ovf_amisha       (ov)
      );

      always @(posedge clk) begin
         if (rst_n) begin
            if (flush) begin
               due_q.delete();
               exp_q.delete();
            end else if (in_valid) begin
               due_q.push_back(cyc + SI);
               exp_q.push_back(model(NI, a_drv, b_drv, sub));
               acc_total++;
            end
         end
      end

      always @(negedge rst_n) begin
         due_q.delete();
         exp_q.delete();
      end

      always @(negedge clk) begin
         if (!rst_n) begin
            check($sformatf("n%0d_s%0d reset_outputs", NI, SI),
                  64'({vo, co, ov, 32'(sum_o)}), 64'd0);
         end else begin
            exp_v = (due_q.size() != 0) && (due_q[0] == cyc);
            if (vo) out_total++;
            if (vo || exp_v) begin
               check($sformatf("n%0d_s%0d out_valid", NI, SI), 64'(vo), 64'(exp_v));
               if (vo && exp_v)
                  check($sformatf("n%0d_s%0d result", NI, SI),
                        64'({ov, co, 32'(sum_o)}), 64'(exp_q[0]));
               if (exp_v) begin
                  void'(due_q.pop_front());
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Single op on the 16-bit/4-stage instance with literal expectations and latency.
   task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [15:0] es, input logic ec, input logic eo);
      int n;
      a_drv    = {16'h0, a};
      b_drv    = {16'h0, b};
      sub      = s;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!g_cfg[0].vo && n < 12) begin
         @(negedge clk);
         n++;
      end
      check({name, " latency"}, 64'(n), 64'd4);
      check({name, " result"}, 64'({g_cfg[0].ov, g_cfg[0].co, g_cfg[0].sum_o}),
            64'({eo, ec, es}));
      @(negedge clk);
      check({name, " single_pulse"}, 64'(g_cfg[0].vo), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int issued, a0, o0, cnt;
      logic [31:0] vals[3];
      rst_n    = 1'b1;
      in_valid = 1'b0;
      sub      = 1'b0;
      flush    = 1'b0;
      a_drv    = '0;
      b_drv    = '0;
      #1 rst_n = 1'b0;

      repeat (6) begin
         @(negedge clk);
         a_drv    = $urandom;
         b_drv    = $urandom;
         sub      = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         flush    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);

      directed("add_0003_0004", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
      directed("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Streaming with random gaps
      repeat (12) @(negedge clk);
      a0 = acc_total;
      o0 = out_total;
      issued = 0;
      while (issued < 100) begin
         in_valid = ($urandom_range(0, 3) != 0);
         a_drv    = $urandom;
         b_drv    = $urandom;
         sub      = 1'($urandom_range(0, 1));
         if (in_valid) issued++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      check("stream_output_count", 64'(out_total - o0), 64'(5 * issued));
      check("stream_accept_count", 64'(acc_total - a0), 64'(5 * issued));

      // Corner vectors: zero, all-ones and MSB-only for each swept width
      foreach (vals[j]) vals[j] = '0;
      for (int w = 0; w < 4; w++) begin
         vals[1] = 32'hFFFF_FFFF;
         vals[2] = 32'd1 << ((w == 0) ? 7 : (w == 1) ? 11 : (w == 2) ? 15 : 31);
         for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++)
               for (int s = 0; s < 2; s++) begin
                  a_drv    = vals[x];
                  b_drv    = vals[y];
                  sub      = 1'(s);
                  in_valid = 1'b1;
                  @(negedge clk);
               end
      end
      in_valid = 1'b0;
      repeat (12) @(negedge clk);

      // Flush mid-flight: third op shares the flush cycle and is discarded
      for (int k = 0; k < 3; k++) begin
         a_drv    = $urandom;
         b_drv    = $urandom;
         sub      = 1'(k);
         in_valid = 1'b1;
         flush    = (k == 2);
         @(negedge clk);
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      cnt = 0;
      repeat (8) begin
         cnt += int'(g_cfg[0].vo);
         @(negedge clk);
      end
      check("flush_no_valid", 64'(cnt), 64'd0);
      directed("after_flush", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Asynchronous reset between clock edges
      for (int k = 0; k < 3; k++) begin
         a_drv    = 32'h0000_0101 * (k + 1);
         b_drv    = 32'h0000_0202;
         sub      = 1'b0;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 check("pre_reset_valid", 64'({g_cfg[0].vo, g_cfg[0].sum_o}), 64'({1'b1, 16'h0303}));
      #1 rst_n = 1'b0;
      #1 check("async_reset_outputs",
               64'({g_cfg[0].vo, g_cfg[0].co, g_cfg[0].ov, g_cfg[0].sum_o}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         cnt += int'(g_cfg[0].vo);
      end
      check("no_stale_after_reset", 64'(cnt), 64'd0);
      directed("after_reset", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      repeat (12) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
